// File: rtl/y86_decode_regfile.sv
// Y86-64 decode stage with integrated 15-entry register file, E/M writeback ports and D/E pipeline register.
// Optional REG_BYPASS_EN: same-cycle writeback data is forwarded into the captured operands.
module y86_decode_regfile #(
    parameter int                DATA_W   = 64,
    parameter int                NUM_REGS = 15,
    parameter int                ADDR_W   = 4,
    parameter int                RSP_IDX  = 4,
    parameter logic [DATA_W-1:0] RESET_SP = 64'h0000_0000_0000_0200
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic [3:0]        in_code,
    input  logic [3:0]        in_fun,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] we_addr,
    input  logic [DATA_W-1:0] we_data,
    input  logic [ADDR_W-1:0] wm_addr,
    input  logic [DATA_W-1:0] wm_data,
    output logic              out_valid,
    output logic [3:0]        out_code,
    output logic [3:0]        out_fun,
    output logic [DATA_W-1:0] val_a,
    output logic [DATA_W-1:0] val_b,
    output logic [ADDR_W-1:0] dst_e,
    output logic [ADDR_W-1:0] dst_m,
    output logic              out_err
);
    localparam logic [ADDR_W-1:0] RNONE = '1;
    localparam logic [ADDR_W-1:0] RSP   = ADDR_W'(RSP_IDX);
    localparam logic [ADDR_W-1:0] NREG  = ADDR_W'(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              we_en, wm_en;

    logic [ADDR_W-1:0] src_a, src_b, dec_dst_e, dec_dst_m;
    logic              dec_err;
    logic [DATA_W-1:0] opnd_a, opnd_b;

    logic              out_valid_q, out_valid_d;
    logic [3:0]        out_code_q, out_code_d;
    logic [3:0]        out_fun_q, out_fun_d;
    logic [DATA_W-1:0] val_a_q, val_a_d;
    logic [DATA_W-1:0] val_b_q, val_b_d;
    logic [ADDR_W-1:0] dst_e_q, dst_e_d;
    logic [ADDR_W-1:0] dst_m_q, dst_m_d;
    logic              out_err_q, out_err_d;

    assign we_en = (we_addr != RNONE) && (we_addr < NREG);
    assign wm_en = (wm_addr != RNONE) && (wm_addr < NREG);

    // M is applied after E so it wins when both target the same register.
    always_comb begin
        regs_d = regs_q;
        if (we_en) regs_d[we_addr] = we_data;
        if (wm_en) regs_d[wm_addr] = wm_data;
    end

    always_comb begin
        src_a     = RNONE;
        src_b     = RNONE;
        dec_dst_e = RNONE;
        dec_dst_m = RNONE;
        dec_err   = 1'b0;
        case (in_code)
            4'h0, 4'h1, 4'h7: ;
            4'h2: begin src_a = ra; dec_dst_e = rb; end
            4'h3: dec_dst_e = rb;
            4'h4: begin src_a = ra; src_b = rb; end
            4'h5: begin src_b = rb; dec_dst_m = ra; end
            4'h6: begin src_a = ra; src_b = rb; dec_dst_e = rb; end
            4'h8: begin src_b = RSP; dec_dst_e = RSP; end
            4'h9: begin src_a = RSP; src_b = RSP; dec_dst_e = RSP; end
            4'hA: begin src_a = ra; src_b = RSP; dec_dst_e = RSP; end
            4'hB: begin src_a = RSP; src_b = RSP; dec_dst_e = RSP; dec_dst_m = ra; end
            default: dec_err = 1'b1;
        endcase
    end

    // Bypass reads the post-write view of the file; otherwise the pre-write view.
    always_comb begin
        opnd_a = '0;
        opnd_b = '0;
`ifdef REG_BYPASS_EN
        if (src_a != RNONE && src_a < NREG) opnd_a = regs_d[src_a];
        if (src_b != RNONE && src_b < NREG) opnd_b = regs_d[src_b];
`else
        if (src_a != RNONE && src_a < NREG) opnd_a = regs_q[src_a];
        if (src_b != RNONE && src_b < NREG) opnd_b = regs_q[src_b];
`endif
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        out_fun_d   = out_fun_q;
        val_a_d     = val_a_q;
        val_b_d     = val_b_q;
        dst_e_d     = dst_e_q;
        dst_m_d     = dst_m_q;
        out_err_d   = out_err_q;
        if (!stall) begin
            out_valid_d = in_valid;
            out_code_d  = in_code;
            out_fun_d   = in_fun;
            val_a_d     = opnd_a;
            val_b_d     = opnd_b;
            dst_e_d     = in_valid ? dec_dst_e : RNONE;
            dst_m_d     = in_valid ? dec_dst_m : RNONE;
            out_err_d   = in_valid & dec_err;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= (i == RSP_IDX) ? RESET_SP : '0;
            out_valid_q <= 1'b0;
            out_code_q  <= 4'h1;
            out_fun_q   <= 4'h0;
            val_a_q     <= '0;
            val_b_q     <= '0;
            dst_e_q     <= RNONE;
            dst_m_q     <= RNONE;
            out_err_q   <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_fun_q   <= out_fun_d;
            val_a_q     <= val_a_d;
            val_b_q     <= val_b_d;
            dst_e_q     <= dst_e_d;
            dst_m_q     <= dst_m_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign out_fun   = out_fun_q;
    assign val_a     = val_a_q;
    assign val_b     = val_b_q;
    assign dst_e     = dst_e_q;
    assign dst_m     = dst_m_q;
    assign out_err   = out_err_q;
endmodule

// File: tb/tb_y86_decode_regfile.sv
// Self-checking bench for y86_decode_regfile: directed scenarios plus randomized traffic
// checked against a behavioural register-file/decode model.
module tb_y86_decode_regfile;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, stall;
  logic [3:0]  in_code, in_fun, ra, rb, we_addr, wm_addr;
  logic [63:0] we_data, wm_data;
  logic        out_valid, out_err;
  logic [3:0]  out_code, out_fun, dst_e, dst_m;
  logic [63:0] val_a, val_b;

  int checks = 0;
  int errors = 0;

`ifdef REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  y86_decode_regfile dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .stall(stall),
    .in_code(in_code), .in_fun(in_fun), .ra(ra), .rb(rb),
    .we_addr(we_addr), .we_data(we_data), .wm_addr(wm_addr), .wm_data(wm_data),
    .out_valid(out_valid), .out_code(out_code), .out_fun(out_fun),
    .val_a(val_a), .val_b(val_b), .dst_e(dst_e), .dst_m(dst_m), .out_err(out_err)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic [63:0] m_regs [15];
  logic        exp_valid, exp_err;
  logic [3:0]  exp_code, exp_fun, exp_de, exp_dm;
  logic [63:0] exp_a, exp_b;

  function automatic logic [3:0] m_src_a(input logic [3:0] c, input logic [3:0] r);
    if (c inside {4'h2, 4'h4, 4'h6, 4'hA}) return r;
    if (c inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_src_b(input logic [3:0] c, input logic [3:0] r);
    if (c inside {4'h4, 4'h5, 4'h6}) return r;
    if (c inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_e(input logic [3:0] c, input logic [3:0] r);
    if (c inside {4'h2, 4'h3, 4'h6}) return r;
    if (c inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_m(input logic [3:0] c, input logic [3:0] r);
    if (c inside {4'h5, 4'hB}) return r;
    return 4'hF;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] id);
    if (id >= 4'd15) return 64'd0;
    if (BYP && wm_addr == id) return wm_data;
    if (BYP && we_addr == id) return we_data;
    return m_regs[id];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = (i == 4) ? 64'h200 : 64'd0;
    exp_valid = 1'b0; exp_code = 4'h1; exp_fun = 4'h0; exp_a = '0; exp_b = '0;
    exp_de = 4'hF; exp_dm = 4'hF; exp_err = 1'b0;
  endtask

  task automatic model_step();
    if (!stall) begin
      exp_valid = in_valid;
      exp_code  = in_code;
      exp_fun   = in_fun;
      exp_a     = m_read(m_src_a(in_code, ra));
      exp_b     = m_read(m_src_b(in_code, rb));
      exp_de    = in_valid ? m_dst_e(in_code, rb) : 4'hF;
      exp_dm    = in_valid ? m_dst_m(in_code, ra) : 4'hF;
      exp_err   = in_valid && (in_code >= 4'hC);
    end
    if (we_addr < 4'd15) m_regs[we_addr] = we_data;
    if (wm_addr < 4'd15) m_regs[wm_addr] = wm_data;
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] f,
                       input logic [3:0] a, input logic [3:0] b, input logic s);
    in_valid = v; in_code = c; in_fun = f; ra = a; rb = b; stall = s;
  endtask

  task automatic drive_wb(input logic [3:0] ea, input logic [63:0] ed,
                          input logic [3:0] ma, input logic [63:0] md);
    we_addr = ea; we_data = ed; wm_addr = ma; wm_data = md;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 1'b0);
    drive_wb(4'hF, '0, 4'hF, '0);
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (val_a !== 64'd0 || val_b !== 64'd0) begin errors++; $display("FAIL reset_vals got %h/%h want 0/0", val_a, val_b); end
    checks++; if (dst_e !== 4'hF || dst_m !== 4'hF) begin errors++; $display("FAIL reset_dst got %h/%h want f/f", dst_e, dst_m); end
    checks++; if (out_code !== 4'h1 || out_fun !== 4'h0 || out_err !== 1'b0) begin errors++; $display("FAIL reset_code got %h/%h/%b want 1/0/0", out_code, out_fun, out_err); end
    drive(1'b1, 4'hA, 4'h0, 4'h0, 4'hF, 1'b0);
    tick();
    checks++; if (val_a !== 64'd0 || val_b !== 64'h200) begin errors++; $display("FAIL push_vals got %h/%h want 0/200", val_a, val_b); end
    checks++; if (dst_e !== 4'h4 || dst_m !== 4'hF || out_valid !== 1'b1) begin errors++; $display("FAIL push_dst got %h/%h/%b want 4/f/1", dst_e, dst_m, out_valid); end
  endtask

  task automatic test_write_then_read();
    drive(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 1'b0);
    drive_wb(4'h3, 64'h1234, 4'hF, '0);
    tick();
    checks++; if (out_valid !== 1'b0 || dst_e !== 4'hF || out_err !== 1'b0) begin errors++; $display("FAIL bubble got v=%b de=%h err=%b want 0/f/0", out_valid, dst_e, out_err); end
    drive(1'b1, 4'h6, 4'h0, 4'h3, 4'h3, 1'b0);
    drive_wb(4'hF, '0, 4'hF, '0);
    tick();
    checks++; if (val_a !== 64'h1234 || val_b !== 64'h1234) begin errors++; $display("FAIL opq_vals got %h/%h want 1234/1234", val_a, val_b); end
    checks++; if (dst_e !== 4'h3 || dst_m !== 4'hF) begin errors++; $display("FAIL opq_dst got %h/%h want 3/f", dst_e, dst_m); end
  endtask

  task automatic test_dual_write();
    drive(1'b0, 4'h1, 4'h0, 4'hF, 4'hF, 1'b0);
    drive_wb(4'h4, 64'h1F8, 4'h4, 64'h77);
    tick();
    drive(1'b1, 4'h2, 4'h0, 4'h4, 4'h1, 1'b0);
    drive_wb(4'hF, '0, 4'hF, '0);
    tick();
    checks++; if (val_a !== 64'h77) begin errors++; $display("FAIL m_wins got %h want 77", val_a); end
  endtask

  task automatic test_bypass();
    logic [63:0] want;
    want = BYP ? 64'hAB : 64'd0;
    drive(1'b1, 4'h2, 4'h0, 4'h2, 4'h6, 1'b0);
    drive_wb(4'h2, 64'hAB, 4'hF, '0);
    tick();
    checks++; if (val_a !== want) begin errors++; $display("FAIL bypass_e got %h want %h", val_a, want); end
    // both ports hit the same source in the decode cycle
    drive(1'b1, 4'h4, 4'h0, 4'h8, 4'h2, 1'b0);
    drive_wb(4'h8, 64'h11, 4'h8, 64'h22);
    want = BYP ? 64'h22 : 64'd0;
    tick();
    checks++; if (val_a !== want || val_b !== 64'hAB) begin errors++; $display("FAIL bypass_m got %h/%h want %h/ab", val_a, val_b, want); end
    drive_wb(4'hF, '0, 4'hF, '0);
  endtask

  task automatic test_stall();
    logic [63:0] fa, fb;
    logic [3:0]  fde;
    drive(1'b1, 4'h6, 4'h3, 4'h3, 4'h2, 1'b0);
    tick();
    fa = val_a; fb = val_b; fde = dst_e;
    checks++; if (fa !== 64'h1234 || fb !== 64'hAB || fde !== 4'h2) begin errors++; $display("FAIL pre_stall got %h/%h/%h want 1234/ab/2", fa, fb, fde); end
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
      if (i == 1) drive_wb(4'h5, 64'h55, 4'hF, '0);
      else drive_wb(4'hF, '0, 4'hF, '0);
      tick();
      checks++;
      if (val_a !== fa || val_b !== fb || dst_e !== fde || out_valid !== 1'b1 || out_code !== 4'h6 || out_fun !== 4'h3)
        begin errors++; $display("FAIL stall_hold cyc%0d got %h/%h/%h/%b/%h/%h want %h/%h/%h/1/6/3", i, val_a, val_b, dst_e, out_valid, out_code, out_fun, fa, fb, fde); end
    end
    drive(1'b1, 4'h6, 4'h0, 4'h5, 4'h5, 1'b0);
    drive_wb(4'hF, '0, 4'hF, '0);
    tick();
    checks++; if (val_a !== 64'h55 || val_b !== 64'h55) begin errors++; $display("FAIL stall_write got %h/%h want 55/55", val_a, val_b); end
  endtask

  task automatic test_illegal_and_reset();
    drive(1'b1, 4'hC, 4'h0, 4'h1, 4'h2, 1'b0);
    tick();
    checks++; if (out_err !== 1'b1 || dst_e !== 4'hF || dst_m !== 4'hF) begin errors++; $display("FAIL illegal got err=%b de=%h dm=%h want 1/f/f", out_err, dst_e, dst_m); end
    drive(1'b1, 4'h6, 4'h0, 4'h3, 4'h3, 1'b0);
    drive_wb(4'h7, 64'hDEAD, 4'h3, 64'hBEEF);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_code !== 4'h1 || out_fun !== 4'h0 || val_a !== 64'd0 || val_b !== 64'd0 ||
        dst_e !== 4'hF || dst_m !== 4'hF || out_err !== 1'b0)
      begin errors++; $display("FAIL async_reset got v=%b c=%h f=%h a=%h b=%h de=%h dm=%h err=%b", out_valid, out_code, out_fun, val_a, val_b, dst_e, dst_m, out_err); end
    @(posedge clock);
    #1 reset_n = 1'b1;
    drive_wb(4'hF, '0, 4'hF, '0);
    drive(1'b1, 4'h6, 4'h0, 4'h3, 4'h7, 1'b0);
    tick();
    checks++; if (val_a !== 64'd0 || val_b !== 64'd0) begin errors++; $display("FAIL reset_regs got %h/%h want 0/0", val_a, val_b); end
    drive(1'b1, 4'hB, 4'h0, 4'h0, 4'hF, 1'b0);
    tick();
    checks++; if (val_a !== 64'h200 || dst_m !== 4'h0 || dst_e !== 4'h4) begin errors++; $display("FAIL reset_sp got %h/%h/%h want 200/0/4", val_a, dst_m, dst_e); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 4) == 0));
      drive_wb(4'($urandom_range(0, 15)), {$urandom, $urandom}, 4'($urandom_range(0, 15)), {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) wm_addr = we_addr;
      tick();
      checks++;
      if (out_valid !== exp_valid || dst_e !== exp_de || dst_m !== exp_dm || out_err !== exp_err)
        begin errors++; $display("FAIL rand_ctl n=%0d got v=%b de=%h dm=%h err=%b want %b/%h/%h/%b", n, out_valid, dst_e, dst_m, out_err, exp_valid, exp_de, exp_dm, exp_err); end
      if (exp_valid) begin
        checks++;
        if (out_code !== exp_code || out_fun !== exp_fun || val_a !== exp_a || val_b !== exp_b)
          begin errors++; $display("FAIL rand_data n=%0d got c=%h f=%h a=%h b=%h want %h/%h/%h/%h", n, out_code, out_fun, val_a, val_b, exp_code, exp_fun, exp_a, exp_b); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_then_read();
    test_dual_write();
    test_bypass();
    test_stall();
    test_illegal_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
